seq_game_ctrl: RTL and testbench

Parametrised controller for the sequence-memory game. It generates a random pattern of multi-bit symbols one symbol per round and plays the whole pattern back to the display. It then accepts and checks the player's guesses symbol by symbol, keeps score, and tracks remaining lives and an input timeout. It replaces the single-bit classic-mode datapath (FSM, bit generator, shift register, counter, input handler, comparator) with one block driving the display and button front-ends directly.

---
 rtl/seq_game_pkg.sv | 24 ++
 rtl/sym_lfsr.sv | 26 ++
 rtl/seq_game_ctrl.sv | 211 +++++++++++++++++++++
 tb/tb_seq_game_ctrl.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_game_pkg.sv
// Shared types and constants for the sequence-memory game controller.
package seq_game_pkg;

    typedef enum logic [2:0] {
        IDLE,
        GEN,
        SHOW,
        WAIT_IN,
        ROUND_OK,
        MISS,
        OVER,
        WIN
    } state_t;

    // 16-bit Galois LFSR, polynomial x^16 + x^14 + x^13 + x^11 + 1 (right-shifting form).
    localparam int                LFSR_W    = 16;
    localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;

    // One Galois step: shift right, fold the dropped bit back through the taps.
    function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] s);
        lfsr_step = s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
    endfunction

endpackage

// File: rtl/sym_lfsr.sv
// Free-running 16-bit pseudo-random source; new pattern symbols are taken
// from its low bits.
module sym_lfsr
    import seq_game_pkg::*;
#(
    parameter logic [LFSR_W-1:0] SEED = 16'hACE1
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic [LFSR_W-1:0] o_state
);

    logic [LFSR_W-1:0] r_state;

    // Advance every cycle regardless of what the game is doing.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= SEED;
        end else begin
            r_state <= lfsr_step(r_state);
        end
    end

    assign o_state = r_state;

endmodule

// File: rtl/seq_game_ctrl.sv
// Sequence-memory game controller: grows a random symbol pattern one symbol
// per round, plays it back, checks the player's guesses, and tracks score,
// lives and an input timeout. All outputs are registered.
module seq_game_ctrl
    import seq_game_pkg::*;
#(
    parameter int                SYM_W       = 2,
    parameter int                MAX_LEN     = 32,
    parameter int                LIVES       = 3,
    parameter int                SHOW_CYCLES = 4,
    parameter int                TIMEOUT     = 1024,
    parameter logic [LFSR_W-1:0] SEED        = 16'hACE1
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           start,
    input  logic                           guess_valid,
    input  logic [SYM_W-1:0]               guess_sym,
    output logic                           show_valid,
    output logic [SYM_W-1:0]               show_sym,
    output logic                           input_en,
    output logic [$clog2(MAX_LEN+1)-1:0]   score,
    output logic [$clog2(LIVES+1)-1:0]     lives_left,
    output logic                           game_over,
    output logic                           win
);

    localparam int SC_W  = $clog2(MAX_LEN + 1);
    localparam int LV_W  = $clog2(LIVES + 1);
    localparam int IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int CYC_W = $clog2(SHOW_CYCLES + 1);
    localparam int TO_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    localparam logic [SC_W-1:0]  LEN_MAX    = SC_W'(MAX_LEN);
    localparam logic [LV_W-1:0]  LIVES_INIT = LV_W'(LIVES);
    localparam logic [CYC_W-1:0] CYC_GAP    = CYC_W'(SHOW_CYCLES);
    localparam logic [CYC_W-1:0] CYC_LAST_ON = CYC_W'(SHOW_CYCLES - 1);
    localparam logic [TO_W-1:0]  TO_LAST    = TO_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    // Control state
    state_t             r_state;
    logic [IDX_W-1:0]   r_idx;
    logic [SC_W-1:0]    r_len;
    logic [SC_W-1:0]    r_score;
    logic [LV_W-1:0]    r_lives;
    logic [CYC_W-1:0]   r_cyc;
    logic [TO_W-1:0]    r_to;

    // Registered outputs
    logic               r_show_valid;
    logic [SYM_W-1:0]   r_show_sym;
    logic               r_input_en;
    logic               r_game_over;
    logic               r_win;

    // Pattern store (data only, never cleared)
    logic [SYM_W-1:0]   r_pat [MAX_LEN];

    logic [LFSR_W-1:0]  w_lfsr;
    logic [SYM_W-1:0]   w_new_sym;
    logic [IDX_W-1:0]   w_idx_nxt;
    logic               w_last;
    logic               w_unused_lfsr;

    sym_lfsr #(
        .SEED    (SEED)
    ) u_lfsr (
        .clk     (clk),
        .rst_n   (rst_n),
        .o_state (w_lfsr)
    );

    assign w_new_sym     = w_lfsr[SYM_W-1:0];
    // Upper LFSR bits only feed the shift chain; fold them so they count as read.
    assign w_unused_lfsr = ^w_lfsr;
    assign w_idx_nxt     = r_idx + 1'b1;
    // idx points at the final stored symbol
    assign w_last        = ((SC_W'(r_idx) + SC_W'(1)) == r_len);

    // Append the freshly generated symbol while in GEN.
    always_ff @(posedge clk) begin
        if (r_state == GEN) begin
            r_pat[r_len[IDX_W-1:0]] <= w_new_sym;
        end
    end

    // Game FSM: sequencing, counters and all registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_idx        <= '0;
            r_len        <= '0;
            r_score      <= '0;
            r_lives      <= LIVES_INIT;
            r_cyc        <= '0;
            r_to         <= '0;
            r_show_valid <= 1'b0;
            r_show_sym   <= '0;
            r_input_en   <= 1'b0;
            r_game_over  <= 1'b0;
            r_win        <= 1'b0;
        end else begin
            case (r_state)
                IDLE, OVER, WIN: begin
                    if (start) begin
                        r_score     <= '0;
                        r_len       <= '0;
                        r_idx       <= '0;
                        r_lives     <= LIVES_INIT;
                        r_game_over <= 1'b0;
                        r_win       <= 1'b0;
                        r_state     <= GEN;
                    end
                end

                GEN: begin
                    // The symbol being written this cycle is not yet readable
                    // from the store, so bypass it when it is the first one.
                    r_len        <= r_len + 1'b1;
                    r_idx        <= '0;
                    r_cyc        <= '0;
                    r_show_valid <= 1'b1;
                    r_show_sym   <= (r_len == '0) ? w_new_sym : r_pat[0];
                    r_state      <= SHOW;
                end

                SHOW: begin
                    if (r_cyc == CYC_GAP) begin
                        // End of the gap after symbol idx
                        if (w_last) begin
                            r_idx      <= '0;
                            r_to       <= '0;
                            r_input_en <= 1'b1;
                            r_state    <= WAIT_IN;
                        end else begin
                            r_idx        <= w_idx_nxt;
                            r_cyc        <= '0;
                            r_show_valid <= 1'b1;
                            r_show_sym   <= r_pat[w_idx_nxt];
                        end
                    end else begin
                        r_cyc <= r_cyc + 1'b1;
                        if (r_cyc == CYC_LAST_ON) begin
                            r_show_valid <= 1'b0;
                            r_show_sym   <= '0;
                        end
                    end
                end

                WAIT_IN: begin
                    // A guess wins over a timeout expiring in the same cycle.
                    if (guess_valid) begin
                        r_to <= '0;
                        if (guess_sym != r_pat[r_idx]) begin
                            r_input_en <= 1'b0;
                            r_state    <= MISS;
                        end else if (w_last) begin
                            r_input_en <= 1'b0;
                            r_state    <= ROUND_OK;
                        end else begin
                            r_idx <= w_idx_nxt;
                        end
                    end else if ((TIMEOUT != 0) && (r_to == TO_LAST)) begin
                        r_input_en <= 1'b0;
                        r_state    <= MISS;
                    end else begin
                        r_to <= r_to + 1'b1;
                    end
                end

                ROUND_OK: begin
                    r_score <= r_score + 1'b1;
                    if (r_len == LEN_MAX) begin
                        r_win   <= 1'b1;
                        r_state <= WIN;
                    end else begin
                        r_state <= GEN;
                    end
                end

                MISS: begin
                    r_lives <= r_lives - 1'b1;
                    if (r_lives == LV_W'(1)) begin
                        r_game_over <= 1'b1;
                        r_state     <= OVER;
                    end else begin
                        // Replay the unchanged pattern from the start
                        r_idx        <= '0;
                        r_cyc        <= '0;
                        r_show_valid <= 1'b1;
                        r_show_sym   <= r_pat[0];
                        r_state      <= SHOW;
                    end
                end

                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign show_valid = r_show_valid;
    assign show_sym   = r_show_sym;
    assign input_en   = r_input_en;
    assign score      = r_score;
    assign lives_left = r_lives;
    assign game_over  = r_game_over;
    assign win        = r_win;

endmodule

// File: tb/tb_seq_game_ctrl.sv
// Bench for seq_game_ctrl: directed game scenarios with randomized guess
// timing, wrong symbols and ignored-input noise, checked against a
// pattern/score/lives model and a reference LFSR.
module tb_seq_game_ctrl;

    localparam int          SYM_W       = 2;
    localparam int          MAX_LEN     = 4;
    localparam int          LIVES       = 3;
    localparam int          SHOW_CYCLES = 4;
    localparam int          TIMEOUT     = 16;
    localparam logic [15:0] SEED        = 16'hACE1;

    logic                          clk = 1'b0;
    logic                          rst_n = 1'b1;
    logic                          start = 1'b0;
    logic                          guess_valid = 1'b0;
    logic [SYM_W-1:0]              guess_sym = '0;
    logic                          show_valid;
    logic [SYM_W-1:0]              show_sym;
    logic                          input_en;
    logic [$clog2(MAX_LEN+1)-1:0]  score;
    logic [$clog2(LIVES+1)-1:0]    lives_left;
    logic                          game_over;
    logic                          win;

    int errs = 0;
    int checks = 0;

    // Model state
    logic [15:0]      m_lfsr;
    logic [SYM_W-1:0] pat [$];
    int               m_score;
    int               m_lives;

    seq_game_ctrl #(
        .SYM_W       (SYM_W),
        .MAX_LEN     (MAX_LEN),
        .LIVES       (LIVES),
        .SHOW_CYCLES (SHOW_CYCLES),
        .TIMEOUT     (TIMEOUT),
        .SEED        (SEED)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .guess_valid (guess_valid),
        .guess_sym   (guess_sym),
        .show_valid  (show_valid),
        .show_sym    (show_sym),
        .input_en    (input_en),
        .score       (score),
        .lives_left  (lives_left),
        .game_over   (game_over),
        .win         (win)
    );

    always #5 clk = ~clk;

    // x^16 + x^14 + x^13 + x^11 + 1: the bit shifted out feeds back into bits 15,13,12,10.
    function automatic logic [15:0] ref_next(input logic [15:0] s);
        logic [15:0] n;
        n = {1'b0, s[15:1]};
        if (s[0]) begin
            n[15] = ~n[15];
            n[13] = ~n[13];
            n[12] = ~n[12];
            n[10] = ~n[10];
        end
        return n;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m_lfsr <= SEED;
        else        m_lfsr <= ref_next(m_lfsr);
    end

    initial begin
        #300000;
        $display("FAIL watchdog: time limit reached, errors=%0d checks=%0d", errs, checks);
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errs++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_show_valid"}, show_valid, 0);
        chk({tag, "_show_sym"}, show_sym, 0);
        chk({tag, "_input_en"}, input_en, 0);
        chk({tag, "_score"}, score, 0);
        chk({tag, "_lives"}, lives_left, LIVES);
        chk({tag, "_game_over"}, game_over, 0);
        chk({tag, "_win"}, win, 0);
    endtask

    // Current cycle is GEN: the stored symbol is the LFSR value right now.
    task automatic do_gen();
        pat.push_back(m_lfsr[SYM_W-1:0]);
        chk("gen_show_valid", show_valid, 0);
        chk("gen_input_en", input_en, 0);
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
        m_score = 0;
        m_lives = LIVES;
        pat.delete();
        chk("start_score", score, 0);
        chk("start_lives", lives_left, LIVES);
        chk("start_game_over", game_over, 0);
        chk("start_win", win, 0);
        do_gen();
    endtask

    // Called in the cycle before playback begins (GEN or MISS); ends in the first WAIT_IN cycle.
    task automatic playback(input bit noisy);
        for (int i = 0; i < pat.size(); i++) begin
            for (int c = 0; c <= SHOW_CYCLES; c++) begin
                if (noisy) begin
                    guess_valid = 1'($urandom_range(0, 1));
                    guess_sym   = SYM_W'($urandom);
                    start       = 1'($urandom_range(0, 1));
                end
                tick();
                if (c < SHOW_CYCLES) begin
                    chk("show_valid_on", show_valid, 1);
                    chk("show_sym", show_sym, pat[i]);
                end else begin
                    chk("show_valid_gap", show_valid, 0);
                    chk("show_sym_gap", show_sym, 0);
                end
                chk("show_input_en", input_en, 0);
                chk("show_score", score, m_score);
                chk("show_lives", lives_left, m_lives);
            end
        end
        tick();
        guess_valid = 1'b0;
        start       = 1'b0;
        chk("wait_input_en", input_en, 1);
        chk("wait_show_valid", show_valid, 0);
    endtask

    // Current cycle is MISS.
    task automatic after_miss();
        if (m_lives == 0) begin
            tick();
            chk("over_game_over", game_over, 1);
            chk("over_lives", lives_left, 0);
            chk("over_input_en", input_en, 0);
            chk("over_show_valid", show_valid, 0);
            chk("over_score", score, m_score);
        end else begin
            playback(1'b0);
        end
    endtask

    // Starts in a WAIT_IN cycle. wrong_at < 0 means every guess is correct.
    task automatic guess_all(input int wrong_at);
        bit done;
        done = 1'b0;
        for (int i = 0; i < pat.size() && !done; i++) begin
            int d;
            d = $urandom_range(0, 3);
            repeat (d) begin
                tick();
                chk("idle_input_en", input_en, 1);
            end
            guess_valid = 1'b1;
            guess_sym   = (i == wrong_at) ? (pat[i] ^ SYM_W'($urandom_range(1, 3))) : pat[i];
            tick();
            guess_valid = 1'b0;
            if (i == wrong_at) begin
                chk("miss_input_en", input_en, 0);
                chk("miss_lives_hold", lives_left, m_lives);
                m_lives--;
                after_miss();
                done = 1'b1;
            end else if (i == pat.size() - 1) begin
                chk("rok_input_en", input_en, 0);
                chk("rok_score_hold", score, m_score);
                tick();
                m_score++;
                chk("rok_score", score, m_score);
                chk("rok_lives", lives_left, m_lives);
                if (pat.size() == MAX_LEN) begin
                    chk("win_flag", win, 1);
                    chk("win_show_valid", show_valid, 0);
                end else begin
                    do_gen();
                end
                done = 1'b1;
            end else begin
                chk("guess_input_en", input_en, 1);
            end
        end
    endtask

    // Starts in the first WAIT_IN cycle; no guesses until expiry.
    task automatic timeout_miss();
        repeat (TIMEOUT - 1) begin
            tick();
            chk("to_input_en", input_en, 1);
        end
        tick();
        chk("to_miss_input_en", input_en, 0);
        chk("to_miss_lives_hold", lives_left, m_lives);
        m_lives--;
        after_miss();
    endtask

    initial begin
        // Reset
        #2 rst_n = 1'b0;
        tick();
        chk_idle_outputs("reset");
        tick();
        rst_n = 1'b1;
        repeat (3) tick();
        chk_idle_outputs("idle_hold");

        // Game A: clean run to WIN, with ignored inputs sprinkled in
        do_start();
        playback(1'b0);
        guess_all(-1);
        playback(1'b1);
        guess_all(-1);
        playback(1'b0);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("start_in_wait_input_en", input_en, 1);
        chk("start_in_wait_score", score, 2);
        guess_all(-1);
        chk("round3_score", score, 3);
        chk("round3_lives", lives_left, 3);
        playback(1'b1);
        guess_all(-1);
        chk("win_score", score, 4);
        guess_valid = 1'b1;
        guess_sym   = '0;
        repeat (3) tick();
        guess_valid = 1'b0;
        chk("win_hold", win, 1);
        chk("win_hold_score", score, 4);
        chk("win_hold_input_en", input_en, 0);

        // Game B: restart from WIN, miss in round 2, then reset mid-playback
        do_start();
        playback(1'b0);
        guess_all(-1);
        playback(1'b0);
        guess_all(0);
        chk("replay_len", pat.size(), 2);
        chk("replay_score", score, 1);
        chk("replay_lives", lives_left, 2);
        guess_all(-1);
        tick();
        tick();
        chk("pre_reset_show_valid", show_valid, 1);
        rst_n = 1'b0;
        #1;
        chk_idle_outputs("mid_show_reset");
        tick();
        tick();
        rst_n = 1'b1;
        repeat (4) tick();
        chk_idle_outputs("post_reset_idle");

        // Game C: three timeouts end the game
        do_start();
        playback(1'b0);
        timeout_miss();
        timeout_miss();
        timeout_miss();
        chk("to_game_over", game_over, 1);
        chk("to_lives", lives_left, 0);
        guess_valid = 1'b1;
        repeat (3) tick();
        guess_valid = 1'b0;
        chk("over_hold", game_over, 1);
        chk("over_hold_input_en", input_en, 0);
        do_start();
        chk("restart_game_over", game_over, 0);
        playback(1'b0);
        guess_all(-1);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
